alarm_sounder: RTL
==================

ALARM_SOUNDER -- requirements
Module: alarm_sounder

Interface
REQ-001 Parameter TONE_DIV, default 4: clock cycles per buzzer half-period (2..255).
REQ-002 Parameter BEEP_ON, default 16: clock cycles per tone burst (1..255).
REQ-003 Parameter BEEP_OFF, default 16: clock cycles of silence between bursts (1..255).
REQ-004 Parameter MAX_BEEPS, default 8: number of bursts before hold (1..15).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 alert  input  1  level from the upstream alarm FSM (bit 0 of its out bus); 1 = alerting.
REQ-008 ack  input  1  one-cycle, already-debounced, active-high acknowledge/mute request.
REQ-009 buzzer  output  1  square-wave tone drive, registered.
REQ-010 led  output  8  burst-position indicator, registered.
REQ-011 beep_count  output  4  number of completed bursts in the current episode, registered.
REQ-012 done  output  1  high while in HOLD, registered.

Function
REQ-013 The block SHALL implement states IDLE, BEEP, GAP, HOLD and MUTED.
REQ-014 IDLE: on an edge with alert=1 and ack=0, go to BEEP with phase, tone and burst counters cleared.
REQ-015 BEEP: the phase counter increments each cycle; when it equals BEEP_ON-1, beep_count increments and the next state is HOLD if the old beep_count = MAX_BEEPS-1, else GAP; the phase counter clears.
REQ-016 GAP: the phase counter increments each cycle; when it equals BEEP_OFF-1, go to BEEP with the phase and tone counters cleared.
REQ-017 In BEEP the tone counter counts 0..TONE_DIV-1 and buzzer toggles on the cycle it wraps; buzzer starts at 0 on BEEP entry.
REQ-018 buzzer SHALL be 0 in every state other than BEEP.
REQ-019 HOLD: done=1, led=8'hFF; stay in HOLD until alert=0, then go to IDLE.
REQ-020 ack=1 in BEEP, GAP or HOLD SHALL go to MUTED next edge; MUTED exits to IDLE only when alert=0.
REQ-021 alert=0 in BEEP or GAP SHALL go to IDLE on the next edge and abandon the burst mid-tone.
REQ-022 Priority on one edge: reset > alert=0 (to IDLE) > ack (to MUTED) > normal sequencing.
REQ-023 ack in IDLE or MUTED SHALL be ignored; alert=1 with ack=1 in IDLE stays IDLE.
REQ-024 led SHALL equal 1 << beep_count[2:0] in BEEP and GAP, 8'hFF in HOLD, 8'h00 in IDLE and MUTED.
REQ-025 beep_count SHALL clear on entry to IDLE and hold its value in HOLD and MUTED.
REQ-026 All counters SHALL be sized from their parameters and SHALL never wrap past their terminal values.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, buzzer=0, led=8'h00, beep_count=0, done=0 and clear all counters, independent of clk.
REQ-028 Reset asserted mid-burst SHALL silence buzzer without waiting for a clock edge; after release the block SHALL need a fresh alert=1 edge sample to re-arm.

Structure
REQ-029 State encodings and default timing constants SHALL live in a shared alarm package/include used by the alarm FSM and this block.
REQ-030 The tone divider SHALL be a sub-module named tone_gen (enable, clear, TONE_DIV parameter, square-wave output).

Verification
REQ-031 Defaults, alert held 1 -> buzzer toggles every 4 cycles for 16 cycles, low 16 cycles, repeats; done=1 exactly 240 cycles after BEEP entry; beep_count=8.
REQ-032 HOLD, then alert dropped -> IDLE next edge, done=0, led=8'h00, beep_count=0.
REQ-033 ack pulse in 3rd burst -> MUTED, buzzer=0, led=8'h00, beep_count=2; alert still 1 -> stays MUTED; alert=0 -> IDLE.
REQ-034 alert=0 and ack=1 on the same edge during GAP -> IDLE, not MUTED.
REQ-035 reset pulsed asynchronously mid-BEEP while buzzer=1 -> buzzer=0 before the next clk edge; all outputs at reset values.
REQ-036 MAX_BEEPS=1, BEEP_ON=1 -> BEEP lasts one cycle, buzzer stays 0, HOLD next edge with beep_count=1.

Source files
------------

// File: rtl/alarm_sounder_pkg.sv
// alarm_sounder_pkg
// Shared definitions for the alarm FSM and the alarm sounder: state
// encoding, default timing constants, LED patterns and small helpers
// for sizing counters and building the burst-position indicator.
package alarm_sounder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEEP,
    ST_GAP,
    ST_HOLD,
    ST_MUTED
  } alarm_state_t;

  localparam int unsigned DEF_TONE_DIV  = 4;
  localparam int unsigned DEF_BEEP_ON   = 16;
  localparam int unsigned DEF_BEEP_OFF  = 16;
  localparam int unsigned DEF_MAX_BEEPS = 8;

  localparam logic [7:0] LED_OFF = 8'h00;
  localparam logic [7:0] LED_ALL = 8'hFF;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot burst-position pattern for the LED bar.
  function automatic logic [7:0] led_pos(input logic [2:0] pos);
    return 8'h01 << pos;
  endfunction

endpackage

// File: rtl/alarm_sounder_if.sv
// alarm_sounder_if
// Signal bundle between the upstream alarm FSM / board and the sounder.
//   alert      : alerting level from the alarm FSM
//   ack        : one-cycle debounced acknowledge / mute request
//   buzzer     : square-wave tone drive
//   led        : burst-position indicator
//   beep_count : completed bursts in the current episode
//   done       : high while holding after the last burst
// master drives alert/ack and observes the rest; slave is the sounder.
interface alarm_sounder_if;
  logic       alert;
  logic       ack;
  logic       buzzer;
  logic [7:0] led;
  logic [3:0] beep_count;
  logic       done;

  modport master (
    output alert,
    output ack,
    input  buzzer,
    input  led,
    input  beep_count,
    input  done
  );

  modport slave (
    input  alert,
    input  ack,
    output buzzer,
    output led,
    output beep_count,
    output done
  );
endinterface

// File: rtl/alarm_sounder_tone_gen.sv
// tone_gen
// Square-wave divider for the buzzer. While enabled the counter runs
// 0..TONE_DIV-1 and the output toggles on the cycle it wraps, giving a
// half-period of TONE_DIV clocks. clear (dominant over enable) forces
// the counter and output low so every burst starts from a silent phase.
// Ports: clk, reset (async, active-high), enable, clear, tone (registered).
module tone_gen
  import alarm_sounder_pkg::*;
#(
  parameter int unsigned TONE_DIV = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tone
);

  localparam int unsigned CW = cnt_w(TONE_DIV);
  localparam logic [CW-1:0] CNT_END = CW'(TONE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (enable) begin
      if (cnt == CNT_END) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_sounder.sv
// alarm_sounder
// Sounds a bounded series of tone bursts while the upstream alarm is
// alerting, then holds with done=1 until the alert clears. An
// acknowledge mutes the episode until the alert drops.
// Ports: clk, reset (async, active-high), bus (alarm_sounder_if.slave:
// alert/ack in; buzzer, led, beep_count, done out, all registered).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | silent, waiting for alert (ack ignored)
// BEEP  | tone burst running, phase counts to BEEP_ON-1
// GAP   | silence between bursts, phase counts to BEEP_OFF-1
// HOLD  | all bursts sounded, done=1, led all on, wait for alert=0
// MUTED | acknowledged, silent, wait for alert=0 (ack ignored)
module alarm_sounder
  import alarm_sounder_pkg::*;
#(
  parameter int unsigned TONE_DIV  = DEF_TONE_DIV,
  parameter int unsigned BEEP_ON   = DEF_BEEP_ON,
  parameter int unsigned BEEP_OFF  = DEF_BEEP_OFF,
  parameter int unsigned MAX_BEEPS = DEF_MAX_BEEPS
) (
  input  logic             clk,
  input  logic             reset,
  alarm_sounder_if.slave   bus
);

  // One phase counter serves both BEEP and GAP, so size it for the longer.
  localparam int unsigned PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int unsigned PH_W   = cnt_w(PH_MAX);
  localparam logic [PH_W-1:0] PH_ON_END  = PH_W'(BEEP_ON - 1);
  localparam logic [PH_W-1:0] PH_OFF_END = PH_W'(BEEP_OFF - 1);
  localparam logic [3:0]      LAST_BEEP  = 4'(MAX_BEEPS - 1);

  alarm_state_t    state;
  logic [PH_W-1:0] phase;
  logic [3:0]      beep_count_q;
  logic [3:0]      bc_inc;
  logic [7:0]      led_q;
  logic            done_q;
  logic            buzzer_q;
  logic            burst_end;
  logic            tone_en;
  logic            tone_run;

  assign bc_inc    = beep_count_q + 4'd1;
  assign burst_end = (phase == PH_ON_END);
  assign tone_en   = (state == ST_BEEP);

  // The tone keeps running only when BEEP continues past this edge. Any
  // exit (burst end, abort, mute) clears it at that same edge, so the
  // buzzer is already low in the first cycle of the next state, and each
  // BEEP entry starts from a cleared divider.
  assign tone_run = (state == ST_BEEP) && bus.alert && !bus.ack && !burst_end;

  tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (tone_en),
    .clear  (!tone_run),
    .tone   (buzzer_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      phase        <= '0;
      beep_count_q <= '0;
      led_q        <= LED_OFF;
      done_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.alert && !bus.ack) begin
            state        <= ST_BEEP;
            phase        <= '0;
            beep_count_q <= '0;
            led_q        <= led_pos(3'd0);
          end
        end

        ST_BEEP, ST_GAP, ST_HOLD: begin
          if (!bus.alert) begin
            // Alert gone wins over ack: abandon the episode outright.
            state        <= ST_IDLE;
            phase        <= '0;
            beep_count_q <= '0;
            led_q        <= LED_OFF;
            done_q       <= 1'b0;
          end else if (bus.ack) begin
            state  <= ST_MUTED;
            phase  <= '0;
            led_q  <= LED_OFF;
            done_q <= 1'b0;
          end else if (state == ST_BEEP) begin
            if (burst_end) begin
              beep_count_q <= bc_inc;
              phase        <= '0;
              if (beep_count_q == LAST_BEEP) begin
                state  <= ST_HOLD;
                led_q  <= LED_ALL;
                done_q <= 1'b1;
              end else begin
                state <= ST_GAP;
                led_q <= led_pos(bc_inc[2:0]);
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end else if (state == ST_GAP) begin
            if (phase == PH_OFF_END) begin
              state <= ST_BEEP;
              phase <= '0;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end

        ST_MUTED: begin
          if (!bus.alert) begin
            state        <= ST_IDLE;
            phase        <= '0;
            beep_count_q <= '0;
            led_q        <= LED_OFF;
            done_q       <= 1'b0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          phase        <= '0;
          beep_count_q <= '0;
          led_q        <= LED_OFF;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.led        = led_q;
  assign bus.beep_count = beep_count_q;
  assign bus.done       = done_q;

endmodule
